// File: rtl/scan_addr_decoder.sv
// Receiving end of a 2-D strided address stream: recovers (x, y) per beat and
// checks each address against the stride/max prediction, with a sticky error.
module scan_addr_decoder #(
    parameter int AW = 32,
    parameter int FW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [15:0]   x_stride,
    input  logic [AW-1:0] y_stride,
    input  logic [AW-1:0] x_max,
    input  logic [AW-1:0] y_max,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] x_idx,
    output logic [AW-1:0] y_idx,
    output logic          last_x,
    output logic          last_frame,
    output logic          mismatch,
    output logic          err,
    output logic [FW-1:0] frame_cnt,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_e;

    state_e        state_q;
    logic [AW-1:0] xs_q, ys_q, xmax_q, ymax_q;
    logic [AW-1:0] x_cnt_q, y_cnt_q, exp_q;
    logic [AW-1:0] x_cnt_d, y_cnt_d, exp_d;
    logic          out_valid_q, last_x_q, last_frame_q, mismatch_q, err_q, busy_q;
    logic [AW-1:0] x_idx_q, y_idx_q;
    logic [FW-1:0] frame_q;
    logic          accept, hit_lx, hit_lf, hit_mis;

    // A beat coinciding with start belongs to neither the old nor the new run.
    assign in_ready = (state_q != IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready && !start;

    assign hit_lx  = (x_cnt_q == xmax_q);
    assign hit_lf  = hit_lx && (y_cnt_q == ymax_q);
    assign hit_mis = (addr != exp_q);

    // Prediction always advances from exp_q, so one bad beat never desyncs the rest.
    always_comb begin
        x_cnt_d = x_cnt_q + AW'(1);
        y_cnt_d = y_cnt_q;
        exp_d   = exp_q + xs_q;
        if (hit_lf) begin
            x_cnt_d = '0;
            y_cnt_d = '0;
            exp_d   = '0;
        end else if (hit_lx) begin
            x_cnt_d = '0;
            y_cnt_d = y_cnt_q + AW'(1);
            exp_d   = exp_q + xs_q + ys_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            xs_q         <= '0;
            ys_q         <= '0;
            xmax_q       <= '0;
            ymax_q       <= '0;
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            exp_q        <= '0;
            out_valid_q  <= 1'b0;
            x_idx_q      <= '0;
            y_idx_q      <= '0;
            last_x_q     <= 1'b0;
            last_frame_q <= 1'b0;
            mismatch_q   <= 1'b0;
            err_q        <= 1'b0;
            frame_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            if (start) begin
                state_q <= RUN;
                busy_q  <= 1'b1;
                xs_q    <= {{(AW-16){1'b0}}, x_stride};
                ys_q    <= y_stride;
                xmax_q  <= x_max;
                ymax_q  <= y_max;
                x_cnt_q <= '0;
                y_cnt_q <= '0;
                exp_q   <= '0;
                err_q   <= 1'b0;
                frame_q <= '0;
            end else if (accept) begin
                x_cnt_q <= x_cnt_d;
                y_cnt_q <= y_cnt_d;
                exp_q   <= exp_d;
                if (hit_lf)
                    frame_q <= frame_q + FW'(1);
                if (hit_mis) begin
                    err_q   <= 1'b1;
                    state_q <= ERR;
                end
            end

            if (accept) begin
                out_valid_q  <= 1'b1;
                x_idx_q      <= x_cnt_q;
                y_idx_q      <= y_cnt_q;
                last_x_q     <= hit_lx;
                last_frame_q <= hit_lf;
                mismatch_q   <= hit_mis;
            end else if (out_ready) begin
                out_valid_q  <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign x_idx      = x_idx_q;
    assign y_idx      = y_idx_q;
    assign last_x     = last_x_q;
    assign last_frame = last_frame_q;
    assign mismatch   = mismatch_q;
    assign err        = err_q;
    assign frame_cnt  = frame_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_scan_addr_decoder.sv
// Bench for scan_addr_decoder: directed vector table, hand sequences for
// backpressure/reset/wrap, and a random run against a frame-position model.
module tb_scan_addr_decoder;

    localparam int AW = 32;
    localparam int FW = 16;

    logic          clk = 1'b0;
    logic          rst_n, start, in_valid, out_ready;
    logic [15:0]   x_stride;
    logic [AW-1:0] y_stride, x_max, y_max, addr;
    logic          in_ready, out_valid, last_x, last_frame, mismatch, err, busy;
    logic [AW-1:0] x_idx, y_idx;
    logic [FW-1:0] frame_cnt;

    always #5 clk = ~clk;

    scan_addr_decoder #(.AW(AW), .FW(FW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x_stride(x_stride), .y_stride(y_stride), .x_max(x_max), .y_max(y_max),
        .in_valid(in_valid), .in_ready(in_ready), .addr(addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_idx(x_idx), .y_idx(y_idx), .last_x(last_x), .last_frame(last_frame),
        .mismatch(mismatch), .err(err), .frame_cnt(frame_cnt), .busy(busy)
    );

    int n_vec = 0;
    int n_bad = 0;
    int d_out = 0;

    // Reference model: position of the next beat within the frame (m_n),
    // address = m_n*x_stride + row*y_stride, all modulo 2^AW.
    logic [AW-1:0]   m_xs, m_ys, m_xm, m_ym;
    longint unsigned m_n;
    logic            m_busy, m_err;
    logic [FW-1:0]   m_frame;
    logic            mo_v, mo_lx, mo_lf, mo_mis;
    logic [AW-1:0]   mo_x, mo_y;

    typedef struct {
        logic          st;
        logic [15:0]   xs;
        logic [AW-1:0] ys, xm, ym, a, ex, ey;
        logic          elx, elf, emis, eerr;
        logic [FW-1:0] efr;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] m_exp();
        longint unsigned w, y, p;
        w = longint'(m_xm) + 1;
        y = m_n / w;
        p = m_n * longint'(m_xs) + y * longint'(m_ys);
        return p[AW-1:0];
    endfunction

    task automatic m_reset();
        m_busy = 0; m_err = 0; m_frame = '0; m_n = 0;
        mo_v = 0; mo_lx = 0; mo_lf = 0; mo_mis = 0; mo_x = '0; mo_y = '0;
    endtask

    task automatic m_beat(input logic [AW-1:0] a);
        longint unsigned w, x, y;
        w = longint'(m_xm) + 1;
        x = m_n % w;
        y = m_n / w;
        mo_v   = 1;
        mo_x   = x[AW-1:0];
        mo_y   = y[AW-1:0];
        mo_lx  = (x == longint'(m_xm));
        mo_lf  = mo_lx && (y == longint'(m_ym));
        mo_mis = (a != m_exp());
        if (mo_mis) m_err = 1;
        if (mo_lf) begin m_n = 0; m_frame = m_frame + 1'b1; end
        else m_n = m_n + 1;
    endtask

    task automatic chk_out();
        if (mo_v)
            chk("beat", 128'({out_valid, x_idx, y_idx, last_x, last_frame, mismatch, err, frame_cnt, busy}),
                        128'({1'b1, mo_x, mo_y, mo_lx, mo_lf, mo_mis, m_err, m_frame, m_busy}));
        else
            chk("idle", 128'({out_valid, err, frame_cnt, busy}), 128'({1'b0, m_err, m_frame, m_busy}));
    endtask

    // One clock: drive at negedge, check in_ready, step model at posedge, check outputs at negedge.
    task automatic cyc(input logic st, input logic iv, input logic [AW-1:0] a, input logic ordy);
        logic er, acc;
        start = st; in_valid = iv; addr = a; out_ready = ordy;
        #1;
        er = m_busy && (!mo_v || ordy);
        chk("in_ready", 128'(in_ready), 128'(er));
        acc = iv && er && !st;
        if (out_valid && ordy) d_out++;
        @(posedge clk);
        if (st) begin
            m_busy = 1; m_err = 0; m_frame = '0; m_n = 0;
            m_xs = {16'h0, x_stride}; m_ys = y_stride; m_xm = x_max; m_ym = y_max;
        end
        if (acc) m_beat(a);
        else if (ordy) mo_v = 0;
        @(negedge clk);
        start = 0;
        chk_out();
    endtask

    task automatic cfg(input logic [15:0] xs, input logic [AW-1:0] ys, xm, ym);
        x_stride = xs; y_stride = ys; x_max = xm; y_max = ym;
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, 128'({out_valid, in_ready, x_idx, y_idx, last_x, last_frame, mismatch, err, frame_cnt, busy}), 128'(0));
    endtask

    initial begin
        int base;
        rst_n = 0; start = 0; in_valid = 0; out_ready = 0; addr = '0;
        cfg(16'd0, '0, '0, '0);
        m_xs = '0; m_ys = '0; m_xm = '0; m_ym = '0;
        m_reset();
        #2;
        chk_zero("reset_state");
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        cyc(0, 1, 32'd0, 1);

        //           st  xs    ys       xm     ym     addr   ex     ey    lx  lf  mis err fr
        tbl.push_back('{1, 16'd4, 32'd16, 32'd2, 32'd1, 32'd0,  32'd0, 32'd0, 0, 0, 0, 0, 16'd0});
        tbl.push_back('{0, 16'd4, 32'd16, 32'd2, 32'd1, 32'd4,  32'd1, 32'd0, 0, 0, 0, 0, 16'd0});
        tbl.push_back('{0, 16'd4, 32'd16, 32'd2, 32'd1, 32'd8,  32'd2, 32'd0, 1, 0, 0, 0, 16'd0});
        tbl.push_back('{0, 16'd4, 32'd16, 32'd2, 32'd1, 32'd28, 32'd0, 32'd1, 0, 0, 0, 0, 16'd0});
        tbl.push_back('{0, 16'd4, 32'd16, 32'd2, 32'd1, 32'd32, 32'd1, 32'd1, 0, 0, 0, 0, 16'd0});
        tbl.push_back('{0, 16'd4, 32'd16, 32'd2, 32'd1, 32'd36, 32'd2, 32'd1, 1, 1, 0, 0, 16'd1});
        tbl.push_back('{0, 16'd4, 32'd16, 32'd2, 32'd1, 32'd0,  32'd0, 32'd0, 0, 0, 0, 0, 16'd1});
        tbl.push_back('{1, 16'd4, 32'd16, 32'd2, 32'd1, 32'd0,  32'd0, 32'd0, 0, 0, 0, 0, 16'd0});
        tbl.push_back('{0, 16'd4, 32'd16, 32'd2, 32'd1, 32'd4,  32'd1, 32'd0, 0, 0, 0, 0, 16'd0});
        tbl.push_back('{0, 16'd4, 32'd16, 32'd2, 32'd1, 32'd9,  32'd2, 32'd0, 1, 0, 1, 1, 16'd0});
        tbl.push_back('{0, 16'd4, 32'd16, 32'd2, 32'd1, 32'd28, 32'd0, 32'd1, 0, 0, 0, 1, 16'd0});
        tbl.push_back('{1, 16'd8, 32'd0,  32'd0, 32'd0, 32'd0,  32'd0, 32'd0, 1, 1, 0, 0, 16'd1});
        tbl.push_back('{0, 16'd8, 32'd0,  32'd0, 32'd0, 32'd0,  32'd0, 32'd0, 1, 1, 0, 0, 16'd2});
        tbl.push_back('{0, 16'd8, 32'd0,  32'd0, 32'd0, 32'd0,  32'd0, 32'd0, 1, 1, 0, 0, 16'd3});

        foreach (tbl[i]) begin
            if (tbl[i].st) begin
                cfg(tbl[i].xs, tbl[i].ys, tbl[i].xm, tbl[i].ym);
                cyc(1, 0, 32'd0, 1);
                cfg(16'hdead, 32'hbeef, 32'd7, 32'd7);
            end
            cyc(0, 1, tbl[i].a, 1);
            chk("tbl", 128'({out_valid, x_idx, y_idx, last_x, last_frame, mismatch, err, frame_cnt}),
                       128'({1'b1, tbl[i].ex, tbl[i].ey, tbl[i].elx, tbl[i].elf, tbl[i].emis, tbl[i].eerr, tbl[i].efr}));
        end

        // Backpressure: out_ready low for 3 cycles while in_valid stays high.
        cfg(16'd4, 32'd16, 32'd2, 32'd1);
        cyc(1, 0, 32'd0, 1);
        base = d_out;
        for (int k = 0; k < 14; k++) begin
            if (m_n + 64'(m_frame) * 6 < 6) cyc(0, 1, m_exp(), !(k >= 2 && k < 5));
            else cyc(0, 0, 32'd0, 1);
        end
        chk("bp_count", 128'(d_out - base), 128'(6));

        // Reset mid-frame after two beats.
        cyc(1, 0, 32'd0, 1);
        cyc(0, 1, 32'd0, 1);
        cyc(0, 1, 32'd4, 0);
        #2 rst_n = 0;
        #1 chk_zero("reset_async");
        m_reset();
        @(negedge clk);
        chk_zero("reset_hold");
        rst_n = 1;
        cyc(0, 1, 32'd0, 1);
        cyc(1, 0, 32'd0, 1);
        cyc(0, 1, 32'd0, 1);
        chk("post_reset", 128'({out_valid, x_idx, y_idx, mismatch}), 128'({1'b1, 64'd0, 1'b0}));

        // Wrap: predictions overflow 2^AW and must still match.
        cfg(16'hffff, 32'hffff0001, 32'd1, 32'd1);
        cyc(1, 0, 32'd0, 1);
        for (int k = 0; k < 4; k++) cyc(0, 1, m_exp(), 1);
        chk("wrap", 128'({frame_cnt, err}), 128'({16'd1, 1'b0}));

        // Random run: sporadic restarts, corrupt addresses, ragged handshakes.
        cfg(16'd3, 32'd5, 32'd2, 32'd2);
        cyc(1, 0, 32'd0, 1);
        for (int i = 0; i < 800; i++) begin
            logic st;
            logic [AW-1:0] a;
            st = ($urandom_range(0, 59) == 0);
            if (st) cfg(16'($urandom), $urandom, AW'($urandom_range(0, 3)), AW'($urandom_range(0, 2)));
            else cfg(16'($urandom), $urandom, $urandom, $urandom);
            a = ($urandom_range(0, 9) == 0) ? AW'($urandom) : m_exp();
            cyc(st, $urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
